// File: rtl/fc_core_ctrl_pkg.sv
// fc_core_ctrl_pkg
//   Shared definitions for the fully-connected core sequencer.
//   FSM state encoding (3 bits): IDLE, CLEAR, RUN, DRAIN, DONE.
package fc_core_ctrl_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] S_CLEAR = 3'd1;
    localparam logic [STATE_W-1:0] S_RUN   = 3'd2;
    localparam logic [STATE_W-1:0] S_DRAIN = 3'd3;
    localparam logic [STATE_W-1:0] S_DONE  = 3'd4;

endpackage

// File: rtl/fc_core_ctrl.sv
// fc_core_ctrl
//   Sequencer in front of the fully-connected MAC core. A start pulse clears
//   the core accumulator, then N node/weight/bias triplets are read from three
//   synchronous-read memories (1-cycle latency) and streamed into the core.
//   The core's output valids are counted and the N-th result is captured.
//
// Ports
//   clk, reset_n           clock, asynchronous active-low reset
//   i_start, i_num         start pulse (honoured in IDLE only), element count
//   o_idle/o_running/o_done  host status (o_done is a one-cycle pulse)
//   o_addr, o_ce           shared read address / enable for the three memories
//   i_node_q/i_wegt_q/i_bias_q  memory read data, valid 1 cycle after o_ce
//   o_core_run             accumulator clear to the core (CLEAR only)
//   o_core_valid, o_core_node/wegt/bias  operand stream to the core
//   i_core_valid, i_core_result  core output
//   o_result, o_result_valid  captured final result and its one-cycle strobe
module fc_core_ctrl
    import fc_core_ctrl_pkg::*;
#(
    parameter int IN_DATA_WIDTH = 8,
    parameter int ADDR_WIDTH    = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i_start,
    input  logic [ADDR_WIDTH-1:0]      i_num,
    output logic                       o_idle,
    output logic                       o_running,
    output logic                       o_done,
    output logic [ADDR_WIDTH-1:0]      o_addr,
    output logic                       o_ce,
    input  logic [IN_DATA_WIDTH-1:0]   i_node_q,
    input  logic [IN_DATA_WIDTH-1:0]   i_wegt_q,
    input  logic [IN_DATA_WIDTH-1:0]   i_bias_q,
    output logic                       o_core_run,
    output logic                       o_core_valid,
    output logic [IN_DATA_WIDTH-1:0]   o_core_node,
    output logic [IN_DATA_WIDTH-1:0]   o_core_wegt,
    output logic [IN_DATA_WIDTH-1:0]   o_core_bias,
    input  logic                       i_core_valid,
    input  logic [4*IN_DATA_WIDTH-1:0] i_core_result,
    output logic [4*IN_DATA_WIDTH-1:0] o_result,
    output logic                       o_result_valid
);

    localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [STATE_W-1:0]         state;
    logic [ADDR_WIDTH-1:0]      num_r;
    logic [ADDR_WIDTH-1:0]      addr_cnt;
    logic [ADDR_WIDTH-1:0]      vld_cnt;
    logic                       core_valid_r;
    logic [4*IN_DATA_WIDTH-1:0] result_r;

    // num_r - 1 is only used when num_r != 0 (CLEAR diverts N=0 to DONE),
    // so the all-ones underflow value never matters.
    logic [ADDR_WIDTH-1:0] last_idx;
    assign last_idx = num_r - ONE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            num_r        <= '0;
            addr_cnt     <= '0;
            vld_cnt      <= '0;
            core_valid_r <= 1'b0;
            result_r     <= '0;
        end else begin
            // Memory data lands one cycle after the read, so the core's
            // valid is simply the read enable delayed by one.
            core_valid_r <= (state == S_RUN);

            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        num_r <= i_num;
                        state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    addr_cnt <= '0;
                    vld_cnt  <= '0;
                    if (num_r == '0) begin
                        result_r <= '0;
                        state    <= S_DONE;
                    end else begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Hold on the last address instead of incrementing so an
                    // all-ones count never wraps back to 0.
                    if (addr_cnt == last_idx) state <= S_DRAIN;
                    else                      addr_cnt <= addr_cnt + ONE;
                end
                S_DRAIN: ;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            // The core's accumulator is final on its N-th valid; capture it
            // then. Placed after the case so DONE takes priority.
            if ((state == S_RUN || state == S_DRAIN) && i_core_valid) begin
                if (vld_cnt == last_idx) begin
                    result_r <= i_core_result;
                    state    <= S_DONE;
                end else begin
                    vld_cnt <= vld_cnt + ONE;
                end
            end
        end
    end

    assign o_idle         = (state == S_IDLE);
    assign o_running      = (state == S_CLEAR) || (state == S_RUN) || (state == S_DRAIN);
    assign o_done         = (state == S_DONE);
    assign o_result_valid = (state == S_DONE);
    assign o_core_run     = (state == S_CLEAR);
    assign o_ce           = (state == S_RUN);
    assign o_addr         = addr_cnt;
    assign o_core_valid   = core_valid_r;
    assign o_core_node    = i_node_q;
    assign o_core_wegt    = i_wegt_q;
    assign o_core_bias    = i_bias_q;
    assign o_result       = result_r;

endmodule

// File: tb/tb_fc_core_ctrl.sv
// tb_fc_core_ctrl
//   Bench for fc_core_ctrl: three synchronous-read memories and a MAC core
//   (clear on run, accumulate node*wegt+bias on valid, 1-cycle output) are
//   modelled around the sequencer. Expected results are sums over the memory
//   contents; expected latency is N+4 (N>=1) or 2 (N=0).
module tb_fc_core_ctrl;

    localparam int W  = 8;
    localparam int AW = 8;
    localparam int RW = 4 * W;

    logic          clk, reset_n, i_start;
    logic [AW-1:0] i_num;
    logic          o_idle, o_running, o_done, o_ce;
    logic [AW-1:0] o_addr;
    logic [W-1:0]  node_q, wegt_q, bias_q;
    logic          o_core_run, o_core_valid;
    logic [W-1:0]  o_core_node, o_core_wegt, o_core_bias;
    logic          core_vld;
    logic [RW-1:0] acc;
    logic [RW-1:0] o_result;
    logic          o_result_valid;

    logic [W-1:0] node_mem [256];
    logic [W-1:0] wegt_mem [256];
    logic [W-1:0] bias_mem [256];

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int cv_cnt = 0;
    int overlap = 0;
    int pair_err = 0;
    logic [AW-1:0] addr_q [$];

    fc_core_ctrl #(.IN_DATA_WIDTH(W), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_num(i_num),
        .o_idle(o_idle), .o_running(o_running), .o_done(o_done),
        .o_addr(o_addr), .o_ce(o_ce),
        .i_node_q(node_q), .i_wegt_q(wegt_q), .i_bias_q(bias_q),
        .o_core_run(o_core_run), .o_core_valid(o_core_valid),
        .o_core_node(o_core_node), .o_core_wegt(o_core_wegt), .o_core_bias(o_core_bias),
        .i_core_valid(core_vld), .i_core_result(acc),
        .o_result(o_result), .o_result_valid(o_result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memories and core model (core is not tied to the sequencer's reset).
    always @(posedge clk) begin
        if (o_ce) begin
            node_q <= node_mem[o_addr];
            wegt_q <= wegt_mem[o_addr];
            bias_q <= bias_mem[o_addr];
        end
        core_vld <= o_core_valid;
        if (o_core_run)
            acc <= '0;
        else if (o_core_valid)
            acc <= acc + RW'(o_core_node) * RW'(o_core_wegt) + RW'(o_core_bias);
    end

    // Protocol monitor.
    always @(negedge clk) begin
        if (o_done === 1'b1) done_cnt++;
        if (o_ce === 1'b1) addr_q.push_back(o_addr);
        if (o_core_valid === 1'b1) cv_cnt++;
        if (o_core_run === 1'b1 && o_core_valid === 1'b1) overlap++;
        if (o_done !== o_result_valid) pair_err++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mems();
        for (int i = 0; i < 256; i++) begin
            node_mem[i] = '0; wegt_mem[i] = '0; bias_mem[i] = '0;
        end
    endtask

    // One job: start with count n, wait (bounded) for o_done, check result,
    // latency, address stream and core-valid count. With spam=1, i_start is
    // held high (with random i_num) for the whole job.
    task automatic run_job(input string tag, input int n, input bit spam);
        logic [63:0] sum;
        logic [RW-1:0] exp_res;
        int lat, dn0, exp_lat;
        bit seq_ok;
        sum = 0;
        for (int i = 0; i < n; i++)
            sum += 64'(node_mem[i]) * 64'(wegt_mem[i]) + 64'(bias_mem[i]);
        exp_res = sum[RW-1:0];
        exp_lat = (n == 0) ? 2 : n + 4;

        @(negedge clk);
        addr_q.delete();
        cv_cnt = 0;
        dn0 = done_cnt;
        i_num = AW'(n);
        i_start = 1'b1;
        @(posedge clk);
        lat = 0;
        for (int k = 1; k <= n + 20; k++) begin
            @(negedge clk);
            if (!spam) i_start = 1'b0;
            else       i_num = AW'($urandom);
            if (o_done === 1'b1) begin
                lat = k;
                break;
            end
        end
        i_start = 1'b0;
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_result"}, 64'(o_result), 64'(exp_res));
        check({tag, "_result_valid"}, 64'(o_result_valid), 64'd1);
        check({tag, "_addr_count"}, 64'(addr_q.size()), 64'(n));
        seq_ok = 1'b1;
        foreach (addr_q[i]) if (addr_q[i] !== AW'(i)) seq_ok = 1'b0;
        check({tag, "_addr_seq"}, 64'(seq_ok), 64'd1);
        if (n > 0) check({tag, "_last_addr"}, 64'(addr_q[$]), 64'(n - 1));
        check({tag, "_core_valids"}, 64'(cv_cnt), 64'(n));
        repeat (2) @(negedge clk);
        check({tag, "_done_pulses"}, 64'(done_cnt - dn0), 64'd1);
        check({tag, "_idle_after"}, 64'(o_idle), 64'd1);
        check({tag, "_result_hold"}, 64'(o_result), 64'(exp_res));
    endtask

    initial begin
        int dn0;
        reset_n = 1'b0;
        i_start = 1'b0;
        i_num   = '0;
        acc     = '0;
        core_vld = 1'b0;
        clear_mems();
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_idle", 64'(o_idle), 64'd1);
        check("rst_running", 64'(o_running), 64'd0);
        check("rst_done", 64'(o_done), 64'd0);
        check("rst_ce", 64'(o_ce), 64'd0);
        check("rst_addr", 64'(o_addr), 64'd0);
        check("rst_core_run", 64'(o_core_run), 64'd0);
        check("rst_core_valid", 64'(o_core_valid), 64'd0);
        check("rst_result", 64'(o_result), 64'd0);
        check("rst_result_valid", 64'(o_result_valid), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // N=2: 2*4+1 + 3*5+1 = 25
        node_mem[0] = 8'd2; node_mem[1] = 8'd3;
        wegt_mem[0] = 8'd4; wegt_mem[1] = 8'd5;
        bias_mem[0] = 8'd1; bias_mem[1] = 8'd1;
        run_job("n2", 2, 1'b0);
        check("n2_const", 64'(o_result), 64'd25);

        // N=0
        run_job("n0", 0, 1'b0);

        // Back-to-back N=1 runs: 6 then 2
        clear_mems();
        node_mem[0] = 8'd2; wegt_mem[0] = 8'd3; bias_mem[0] = 8'd0;
        run_job("b2b_a", 1, 1'b0);
        node_mem[0] = 8'd1; wegt_mem[0] = 8'd1; bias_mem[0] = 8'd1;
        run_job("b2b_b", 1, 1'b0);
        check("b2b_const", 64'(o_result), 64'd2);

        // i_start held during a run of N=4
        for (int i = 0; i < 4; i++) begin
            node_mem[i] = AW'(i + 1); wegt_mem[i] = 8'd2; bias_mem[i] = 8'd1;
        end
        run_job("spam", 4, 1'b1);

        // Reset in the middle of a run of N=8, then N=3 all ones -> 6
        for (int i = 0; i < 8; i++) begin
            node_mem[i] = 8'd1; wegt_mem[i] = 8'd1; bias_mem[i] = 8'd1;
        end
        @(negedge clk);
        i_num = 8'd8;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (4) @(negedge clk);
        dn0 = done_cnt;
        reset_n = 1'b0;
        #1;
        check("mid_rst_idle", 64'(o_idle), 64'd1);
        check("mid_rst_running", 64'(o_running), 64'd0);
        check("mid_rst_ce", 64'(o_ce), 64'd0);
        check("mid_rst_core_valid", 64'(o_core_valid), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (15) @(negedge clk);
        check("mid_rst_no_done", 64'(done_cnt - dn0), 64'd0);
        run_job("after_rst", 3, 1'b0);
        check("after_rst_const", 64'(o_result), 64'd6);

        // Maximum count, all operands 255
        for (int i = 0; i < 256; i++) begin
            node_mem[i] = 8'hFF; wegt_mem[i] = 8'hFF; bias_mem[i] = 8'hFF;
        end
        run_job("max", 255, 1'b0);
        check("max_const", 64'(o_result), 64'd16646400);

        // Randomized jobs
        for (int t = 0; t < 6; t++) begin
            int n;
            n = int'($urandom_range(1, 16));
            for (int i = 0; i < 256; i++) begin
                node_mem[i] = W'($urandom); wegt_mem[i] = W'($urandom); bias_mem[i] = W'($urandom);
            end
            run_job($sformatf("rand%0d", t), n, t[0]);
        end

        check("no_run_valid_overlap", 64'(overlap), 64'd0);
        check("done_eq_result_valid", 64'(pair_err), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
